// File: rtl/ram_sync_nolatch_nrnw_clr.sv
// Multi-port register-file RAM: NUM_RD combinational reads, NUM_WR synchronous writes
// (highest port wins), hardware clear sweep, optional write-first bypass, debug peek.
`ifndef ADDR_LEN
`define ADDR_LEN 5
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module ram_sync_nolatch_nrnw_clr #(
  parameter int                         BRAM_ADDR_WIDTH = `ADDR_LEN,
  parameter int                         BRAM_DATA_WIDTH = `DATA_LEN,
  parameter int                         DATA_DEPTH      = 32,
  parameter int                         NUM_RD          = 4,
  parameter int                         NUM_WR          = 2,
  parameter bit                         BYPASS          = 1'b0,
  parameter logic [BRAM_DATA_WIDTH-1:0] CLEAR_VALUE     = '0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clear,
  input  logic [NUM_RD*BRAM_ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_RD*BRAM_DATA_WIDTH-1:0]   rdata,
  input  logic [NUM_WR*BRAM_ADDR_WIDTH-1:0]   waddr,
  input  logic [NUM_WR*BRAM_DATA_WIDTH-1:0]   wdata,
  input  logic [NUM_WR-1:0]                   we,
  output logic                                busy,
  output logic                                wr_conflict,
  input  logic [BRAM_ADDR_WIDTH-1:0]          dbg_addr,
  output logic [BRAM_DATA_WIDTH-1:0]          dbg_data
);

  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int DW = BRAM_DATA_WIDTH;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DATA_DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DATA_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [AW-1:0]  clr_ptr_r, clr_ptr_nxt_s;
  logic           busy_r, busy_nxt_s;
  logic           conflict_r, conflict_nxt_s;
  logic [DW-1:0]  mem_r [DATA_DEPTH];

  logic [AW-1:0]  wa_s [NUM_WR];
  logic [DW-1:0]  wd_s [NUM_WR];
  logic [NUM_WR-1:0] wvalid_s;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < DEPTH_C);
  endfunction

  // Unpack write ports; a write is accepted only in READY, in range, and not on a clear edge
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wa_s[j]     = waddr[j*AW +: AW];
      wd_s[j]     = wdata[j*DW +: DW];
      wvalid_s[j] = we[j] && in_range(wa_s[j]) && (state_r == ST_READY) && !clear;
    end
  end

  // Flag any pair of accepted writes aimed at the same entry
  always_comb begin
    conflict_nxt_s = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int k = i + 1; k < NUM_WR; k++) begin
        if (wvalid_s[i] && wvalid_s[k] && (wa_s[i] == wa_s[k])) begin
          conflict_nxt_s = 1'b1;
        end else begin
          conflict_nxt_s = conflict_nxt_s;
        end
      end
    end
  end

  // Clear-sweep sequencer next state; a clear request restarts the sweep from any state
  always_comb begin
    state_nxt_s   = state_r;
    clr_ptr_nxt_s = clr_ptr_r;
    busy_nxt_s    = busy_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_ptr_r == LAST_C) begin
          state_nxt_s = ST_READY;
          busy_nxt_s  = 1'b0;
        end else begin
          clr_ptr_nxt_s = clr_ptr_r + AW'(1);
        end
      end
      ST_READY: begin
        busy_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s   = ST_CLEAR;
        clr_ptr_nxt_s = '0;
        busy_nxt_s    = 1'b1;
      end
    endcase
    if (clear) begin
      state_nxt_s   = ST_CLEAR;
      clr_ptr_nxt_s = '0;
      busy_nxt_s    = 1'b1;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Sequencer and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_CLEAR;
      clr_ptr_r  <= '0;
      busy_r     <= 1'b1;
      conflict_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      clr_ptr_r  <= clr_ptr_nxt_s;
      busy_r     <= busy_nxt_s;
      conflict_r <= conflict_nxt_s;
    end
  end

  // Storage array: sweep writes CLEAR_VALUE, otherwise later ports override earlier ones
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[clr_ptr_r] <= CLEAR_VALUE;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wvalid_s[j]) begin
          mem_r[wa_s[j]] <= wd_s[j];
        end
      end
    end
  end

  // Combinational read ports with optional write-first forwarding
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (busy_r || !in_range(raddr[k*AW +: AW])) begin
        rdata[k*DW +: DW] = CLEAR_VALUE;
      end else begin
        rdata[k*DW +: DW] = mem_r[raddr[k*AW +: AW]];
        for (int j = 0; j < NUM_WR; j++) begin
          if (BYPASS && wvalid_s[j] && (wa_s[j] == raddr[k*AW +: AW])) begin
            rdata[k*DW +: DW] = wd_s[j];
          end else begin
            rdata[k*DW +: DW] = rdata[k*DW +: DW];
          end
        end
      end
    end
  end

  // Debug peek never forwards in-flight writes
  always_comb begin
    if (busy_r || !in_range(dbg_addr)) begin
      dbg_data = CLEAR_VALUE;
    end else begin
      dbg_data = mem_r[dbg_addr];
    end
  end

  assign busy        = busy_r;
  assign wr_conflict = conflict_r;

endmodule

// File: tb/tb_ram_sync_nolatch_nrnw_clr.sv
// Scoreboard bench: two instances (depth 32 read-old, depth 24 write-first) share stimulus
// and are checked against an array-level reference model.
module tb_ram_sync_nolatch_nrnw_clr;

  localparam logic [31:0] CV = 32'hDEADBEEF;

  logic         clk = 1'b0;
  logic         reset, clear;
  logic [19:0]  raddr;
  logic [9:0]   waddr;
  logic [63:0]  wdata;
  logic [1:0]   we;
  logic [4:0]   dbg_addr;
  logic [127:0] rdata_a, rdata_b;
  logic         busy_a, busy_b, conf_a, conf_b;
  logic [31:0]  dbg_a, dbg_b;

  always #5 clk = ~clk;

  ram_sync_nolatch_nrnw_clr #(.BRAM_ADDR_WIDTH(5), .BRAM_DATA_WIDTH(32), .DATA_DEPTH(32),
    .NUM_RD(4), .NUM_WR(2), .BYPASS(1'b0), .CLEAR_VALUE(CV)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .raddr(raddr), .rdata(rdata_a),
    .waddr(waddr), .wdata(wdata), .we(we), .busy(busy_a), .wr_conflict(conf_a),
    .dbg_addr(dbg_addr), .dbg_data(dbg_a));

  ram_sync_nolatch_nrnw_clr #(.BRAM_ADDR_WIDTH(5), .BRAM_DATA_WIDTH(32), .DATA_DEPTH(24),
    .NUM_RD(4), .NUM_WR(2), .BYPASS(1'b1), .CLEAR_VALUE(CV)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .raddr(raddr), .rdata(rdata_b),
    .waddr(waddr), .wdata(wdata), .we(we), .busy(busy_b), .wr_conflict(conf_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b));

  typedef struct packed {
    logic         busy;
    logic         conf;
    logic [127:0] rd;
    logic [31:0]  dbg;
  } exp_t;

  exp_t exp_q [2][$];

  // reference model: per instance
  logic [31:0] mm [2][32];
  int          depth_m [2] = '{32, 24};
  bit          byp_m   [2] = '{1'b0, 1'b1};
  bit          busy_m  [2] = '{1'b1, 1'b1};
  int          idx_m   [2] = '{0, 0};
  bit          conf_m  [2] = '{1'b0, 1'b0};

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  function automatic int wa(int j); return int'(waddr[j*5 +: 5]); endfunction
  function automatic logic [31:0] wd(int j); return wdata[j*32 +: 32]; endfunction

  task automatic model_edge(int d);
    bit c;
    if (reset || clear) begin
      busy_m[d] = 1'b1; idx_m[d] = 0; conf_m[d] = 1'b0;
    end else if (busy_m[d]) begin
      mm[d][idx_m[d]] = CV;
      if (idx_m[d] == depth_m[d] - 1) busy_m[d] = 1'b0;
      else idx_m[d] = idx_m[d] + 1;
      conf_m[d] = 1'b0;
    end else begin
      c = 1'b0;
      for (int j = 0; j < 2; j++)
        if (we[j] && wa(j) < depth_m[d]) mm[d][wa(j)] = wd(j);
      if (we == 2'b11 && wa(0) == wa(1) && wa(0) < depth_m[d]) c = 1'b1;
      conf_m[d] = c;
    end
  endtask

  function automatic exp_t calc(int d);
    exp_t e;
    int a;
    logic [31:0] v;
    e.busy = busy_m[d];
    e.conf = conf_m[d];
    for (int k = 0; k < 4; k++) begin
      a = int'(raddr[k*5 +: 5]);
      v = CV;
      if (!busy_m[d] && a < depth_m[d]) begin
        v = mm[d][a];
        if (byp_m[d] && !clear)
          for (int j = 0; j < 2; j++)
            if (we[j] && wa(j) < depth_m[d] && wa(j) == a) v = wd(j);
      end
      e.rd[k*32 +: 32] = v;
    end
    a = int'(dbg_addr);
    e.dbg = (!busy_m[d] && a < depth_m[d]) ? mm[d][a] : CV;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic apply();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        busy_m[d] = 1'b1; idx_m[d] = 0; conf_m[d] = 1'b0;
      end
      exp_q[d].push_back(calc(d));
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, expv);
    end
  endtask

  task automatic compare(string tag, exp_t e, logic b, logic c, logic [127:0] rd, logic [31:0] dg);
    chk({tag, ".busy"}, 32'(b), 32'(e.busy));
    chk({tag, ".wr_conflict"}, 32'(c), 32'(e.conf));
    for (int k = 0; k < 4; k++) chk($sformatf("%s.rdata%0d", tag, k), rd[k*32 +: 32], e.rd[k*32 +: 32]);
    chk({tag, ".dbg_data"}, dg, e.dbg);
  endtask

  // monitor: pops one expectation per instance each cycle, away from the active edge
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (exp_q[0].size() > 0) begin
        e = exp_q[0].pop_front();
        compare("a", e, busy_a, conf_a, rdata_a, dbg_a);
      end
      if (exp_q[1].size() > 0) begin
        e = exp_q[1].pop_front();
        compare("b", e, busy_b, conf_b, rdata_b, dbg_b);
      end
    end
  end

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      tick(); we = 2'b00; clear = 1'b0; apply();
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 32; a += 4) begin
      tick();
      we = 2'b00;
      raddr = {5'(a + 3), 5'(a + 2), 5'(a + 1), 5'(a)};
      dbg_addr = 5'(a + 1);
      apply();
    end
  endtask

  task automatic rand_inputs();
    we = 2'($urandom_range(0, 3));
    waddr[4:0] = 5'($urandom_range(0, 31));
    waddr[9:5] = ($urandom_range(0, 3) == 0) ? waddr[4:0] : 5'($urandom_range(0, 31));
    wdata = {32'($urandom), 32'($urandom)};
    for (int k = 0; k < 4; k++)
      raddr[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? waddr[($urandom_range(0, 1))*5 +: 5]
                                                    : 5'($urandom_range(0, 31));
    dbg_addr = 5'($urandom_range(0, 31));
    clear = ($urandom_range(0, 149) == 0);
    reset = ($urandom_range(0, 399) == 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) mm[d][i] = CV;
    reset = 1'b1; clear = 1'b0; we = 2'b00; waddr = '0; wdata = '0; raddr = '0; dbg_addr = '0;
    tick(); apply();
    tick(); apply();
    tick(); reset = 1'b0; apply();

    // sweep after reset, with a write attempt to entry 3 mid-sweep
    for (int c = 1; c <= 40; c++) begin
      tick();
      we = 2'b00;
      if (c == 10) begin
        we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h12345678};
      end
      raddr = {5'd3, 5'd2, 5'd1, 5'd3};
      dbg_addr = 5'd3;
      apply();
    end
    read_all();

    // colliding writes, then distinct writes
    tick(); we = 2'b11; waddr = {5'd5, 5'd5}; wdata = {32'h22, 32'h11};
    raddr = {5'd5, 5'd5, 5'd5, 5'd5}; dbg_addr = 5'd5; apply();
    idle_cycles(2);
    tick(); we = 2'b11; waddr = {5'd9, 5'd8}; wdata = {32'h99, 32'h88};
    raddr = {5'd9, 5'd8, 5'd9, 5'd8}; apply();
    idle_cycles(2);

    // read-old vs write-first on entry 7
    tick(); we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'hA}; apply();
    tick(); we = 2'b01; wdata = {32'h0, 32'hB}; raddr = {5'd7, 5'd7, 5'd7, 5'd7}; dbg_addr = 5'd7; apply();
    idle_cycles(1);
    tick(); we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'hD, 32'hC}; apply();
    idle_cycles(1);

    // out-of-range for the depth-24 instance
    tick(); we = 2'b01; waddr = {5'd0, 5'd30}; wdata = {32'h0, 32'h55};
    raddr = {5'd23, 5'd24, 5'd31, 5'd30}; dbg_addr = 5'd30; apply();
    tick(); we = 2'b11; waddr = {5'd30, 5'd30}; apply();
    idle_cycles(2);
    read_all();

    // clear with a simultaneous write, then a restart mid-sweep
    tick(); clear = 1'b1; we = 2'b01; waddr = {5'd0, 5'd2}; wdata = {32'h0, 32'h77};
    raddr = {5'd2, 5'd2, 5'd2, 5'd2}; apply();
    idle_cycles(14);
    tick(); clear = 1'b1; apply();
    idle_cycles(40);
    read_all();

    // async reset between edges mid-sweep
    tick(); clear = 1'b1; apply();
    idle_cycles(19);
    tick(); reset = 1'b1; apply();
    tick(); apply();
    tick(); reset = 1'b0; apply();
    idle_cycles(40);
    read_all();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      tick(); rand_inputs(); apply();
    end
    tick(); reset = 1'b0; clear = 1'b0; we = 2'b00; apply();
    idle_cycles(40);
    read_all();

    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
    chk("scoreboard_drain_a", 32'(exp_q[0].size()), 32'd0);
    chk("scoreboard_drain_b", 32'(exp_q[1].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
